// File: rtl/ctx_fsm_pkg.sv
// ctx_fsm_pkg
// Shared types and helpers for the context-switched serial core scheduler.
//   sched_state_e : scheduler FSM states (IDLE, LOAD, RUN, STORE)
//   ab_step()     : one step of the two-bit Mealy core, returns {y, a_next, b_next}
package ctx_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      STORE = 2'd3
   } sched_state_e;

   // Core equations: y = a^x^b, a' = b, b' = ~(a^x); ab packs {a, b}.
   function automatic logic [2:0] ab_step(input logic [1:0] ab, input logic x);
      logic a_v;
      logic b_v;
      a_v = ab[1];
      b_v = ab[0];
      return {a_v ^ x ^ b_v, b_v, ~(a_v ^ x)};
   endfunction

endpackage

// File: rtl/ctx_fsm_sched_core.sv
// ab_fsm_core
// The shared two-bit Mealy serial core. Holds (a,b); the scheduler swaps
// channel contexts in and out through load/load_val.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load, load_val  : replace (a,b) with a saved channel context
//   clear           : force (a,b) to (0,0); wins over load and step
//   step, x         : advance the core by one input bit x
//   state           : current {a,b}
//   y               : combinational output for the current (a,b,x)
module ab_fsm_core
   import ctx_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [1:0] load_val,
   input  logic       clear,
   input  logic       step,
   input  logic       x,
   output logic [1:0] state,
   output logic       y
);

   logic [1:0] ab_r;
   logic [2:0] step_s;

   // Next state and output of the core for the presented bit
   always_comb begin
      step_s = ab_step(ab_r, x);
   end

   assign y     = step_s[2];
   assign state = ab_r;

   // Core state register: clear beats load beats step
   always_ff @(posedge clk) begin
      if (reset) begin
         ab_r <= 2'b00;
      end else if (clear) begin
         ab_r <= 2'b00;
      end else if (load) begin
         ab_r <= load_val;
      end else if (step) begin
         ab_r <= step_s[1:0];
      end else begin
         ab_r <= ab_r;
      end
   end

endmodule

// File: rtl/ctx_fsm_sched.sv
// ctx_fsm_sched
// Round-robin burst scheduler time-sharing one ab_fsm_core among NCH
// bit-stream requesters, saving/restoring each channel's (a,b) context.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req_valid  : [NCH] channel i has a bit to present
//   req_bit    : [NCH] bit offered by channel i
//   req_ready  : [NCH] one-hot, granted channel while in RUN
//   ch_clear   : [NCH] force context of channel i to (0,0)
//   out_valid  : one-cycle pulse per processed bit
//   out_bit    : core output y for that bit
//   out_ch     : [CHW] channel that produced out_bit
//   busy       : FSM not in IDLE
module ctx_fsm_sched
   import ctx_fsm_pkg::*;
#(
   parameter  int NCH   = 4,
   parameter  int BURST = 8,
   localparam int CHW   = $clog2(NCH)
)
(
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] req_valid,
   input  logic [NCH-1:0] req_bit,
   output logic [NCH-1:0] req_ready,
   input  logic [NCH-1:0] ch_clear,
   output logic           out_valid,
   output logic           out_bit,
   output logic [CHW-1:0] out_ch,
   output logic           busy
);

   localparam int             CNTW     = $clog2(BURST + 1);
   localparam logic [CNTW-1:0] BURST_C  = CNTW'(BURST);
   localparam logic [CHW-1:0]  LAST_RST = CHW'(NCH - 1);

   sched_state_e    state_r;
   sched_state_e    state_next_s;
   logic [CHW-1:0]  cur_r;
   logic [CHW-1:0]  last_grant_r;
   logic [CNTW-1:0] cnt_r;
   logic [1:0]      ctx_r [NCH];
   logic [CHW-1:0]  pick_s;
   logic [CHW-1:0]  cand_s;
   logic            any_req_s;
   logic            accept_s;
   logic [NCH-1:0]  req_ready_s;
   logic [1:0]      core_state_s;
   logic            core_y_s;
   logic            core_clear_s;
   logic            out_valid_r;
   logic            out_bit_r;
   logic [CHW-1:0]  out_ch_r;

   // Round-robin search: scan from farthest to nearest so the nearest
   // requester after last_grant is the one that sticks
   always_comb begin
      pick_s    = '0;
      any_req_s = 1'b0;
      cand_s    = '0;
      for (int i = NCH; i >= 1; i--) begin
         cand_s = CHW'((int'(last_grant_r) + i) % NCH);
         if (req_valid[cand_s]) begin
            pick_s    = cand_s;
            any_req_s = 1'b1;
         end else begin
            pick_s    = pick_s;
         end
      end
   end

   // Next-state logic, grant and accept decode
   always_comb begin
      state_next_s = state_r;
      req_ready_s  = '0;
      accept_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_next_s = LOAD;
            end else begin
               state_next_s = IDLE;
            end
         end
         LOAD: begin
            state_next_s = RUN;
         end
         RUN: begin
            req_ready_s[cur_r] = 1'b1;
            if (req_valid[cur_r]) begin
               accept_s = 1'b1;
               // this accept exhausts the burst
               if (cnt_r + CNTW'(1) == BURST_C) begin
                  state_next_s = STORE;
               end else begin
                  state_next_s = RUN;
               end
            end else begin
               state_next_s = STORE;
            end
         end
         STORE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Clear only hits the live core when the cleared channel owns it
   assign core_clear_s = ch_clear[cur_r] && ((state_r == LOAD) || (state_r == RUN));

   ab_fsm_core u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (state_r == LOAD),
      .load_val (ctx_r[cur_r]),
      .clear    (core_clear_s),
      .step     (accept_s),
      .x        (req_bit[cur_r]),
      .state    (core_state_s),
      .y        (core_y_s)
   );

   // FSM, RR pointer, burst counter and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         cur_r        <= '0;
         last_grant_r <= LAST_RST;
         cnt_r        <= '0;
         out_valid_r  <= 1'b0;
         out_bit_r    <= 1'b0;
         out_ch_r     <= '0;
      end else begin
         state_r     <= state_next_s;
         out_valid_r <= accept_s;
         if (accept_s) begin
            out_bit_r <= core_y_s;
            out_ch_r  <= cur_r;
         end
         if ((state_r == IDLE) && any_req_s) begin
            cur_r <= pick_s;
         end
         if (state_r == LOAD) begin
            cnt_r <= '0;
         end else if (accept_s) begin
            cnt_r <= cnt_r + CNTW'(1);
         end
         if (state_r == STORE) begin
            last_grant_r <= cur_r;
         end
      end
   end

   // Context array: STORE write first, ch_clear afterwards so it wins
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            ctx_r[i] <= 2'b00;
         end
      end else begin
         if (state_r == STORE) begin
            ctx_r[cur_r] <= core_state_s;
         end
         for (int i = 0; i < NCH; i++) begin
            if (ch_clear[i]) begin
               ctx_r[i] <= 2'b00;
            end
         end
      end
   end

   // Grant and busy are forced low while reset is asserted
   assign req_ready = reset ? '0 : req_ready_s;
   assign busy      = !reset && (state_r != IDLE);
   assign out_valid = out_valid_r;
   assign out_bit   = out_bit_r;
   assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_ctx_fsm_sched.sv
// tb_ctx_fsm_sched
// Directed bench for ctx_fsm_sched. u_dut uses BURST=8, u_dut2 uses BURST=2.
// Cycle 0 of each scenario is the first IDLE cycle in which requests appear.
module tb_ctx_fsm_sched;
   import ctx_fsm_pkg::*;

   localparam int NCH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req_valid, req_bit, req_ready, ch_clear;
   logic       out_valid, out_bit, busy;
   logic [1:0] out_ch;
   logic [3:0] req_valid2, req_bit2, req_ready2, ch_clear2;
   logic       out_valid2, out_bit2, busy2;
   logic [1:0] out_ch2;

   always #5 clk = ~clk;

   ctx_fsm_sched #(.NCH(4), .BURST(8)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_bit(req_bit),
      .req_ready(req_ready), .ch_clear(ch_clear), .out_valid(out_valid),
      .out_bit(out_bit), .out_ch(out_ch), .busy(busy)
   );

   ctx_fsm_sched #(.NCH(4), .BURST(2)) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid2), .req_bit(req_bit2),
      .req_ready(req_ready2), .ch_clear(ch_clear2), .out_valid(out_valid2),
      .out_bit(out_bit2), .out_ch(out_ch2), .busy(busy2)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // requester models: bits leave LSB first, left counts bits still to send
   logic [31:0] pat [NCH];
   int          left [NCH];
   logic [31:0] pat2 [NCH];
   int          left2 [NCH];

   // values sampled at the falling edge of the current cycle
   logic [3:0] o_ready, o_acc, o_bits, o_ready2;
   logic       o_ov, o_ob, o_busy, o_ov2, o_ob2, o_busy2;
   logic [1:0] o_och, o_och2;

   task automatic drive_reqs();
      for (int ch = 0; ch < NCH; ch++) begin
         req_valid[ch]  = (left[ch] > 0);
         req_bit[ch]    = pat[ch][0];
         req_valid2[ch] = (left2[ch] > 0);
         req_bit2[ch]   = pat2[ch][0];
      end
   endtask

   task automatic clear_reqs();
      for (int ch = 0; ch < NCH; ch++) begin
         pat[ch] = '0; left[ch] = 0; pat2[ch] = '0; left2[ch] = 0;
      end
      drive_reqs();
   endtask

   // sample one cycle, then advance requesters past the rising edge
   task automatic step();
      logic [3:0] acc2;
      @(negedge clk);
      o_ready = req_ready; o_bits = req_bit; o_ov = out_valid; o_ob = out_bit;
      o_och = out_ch; o_busy = busy; o_acc = req_ready & req_valid;
      o_ready2 = req_ready2; o_ov2 = out_valid2; o_ob2 = out_bit2;
      o_och2 = out_ch2; o_busy2 = busy2; acc2 = req_ready2 & req_valid2;
      @(posedge clk);
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
         if (o_acc[ch]) begin pat[ch] = pat[ch] >> 1; left[ch]--; end
         if (acc2[ch]) begin pat2[ch] = pat2[ch] >> 1; left2[ch]--; end
      end
      drive_reqs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ch_clear = 4'b0000; ch_clear2 = 4'b0000;
      clear_reqs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      clear_reqs();
      for (int i = 0; i < 40; i++) begin
         step();
         if (!o_busy && !o_busy2) break;
      end
      tests_run++;
      if (o_busy || o_busy2) begin
         tests_failed++;
         $display("FAIL %s idle_timeout got busy=%b/%b exp 0/0", tag, o_busy, o_busy2);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ch_clear = 4'b0000; ch_clear2 = 4'b0000;
      for (int ch = 0; ch < NCH; ch++) begin
         pat[ch] = '1; left[ch] = 100; pat2[ch] = '1; left2[ch] = 100;
      end
      drive_reqs();
      @(negedge clk);
      tests_run++;
      if (req_ready !== 4'b0000 || busy !== 1'b0 || req_ready2 !== 4'b0000 || busy2 !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_comb got ready=%b busy=%b ready2=%b busy2=%b exp 0000 0", req_ready, busy, req_ready2, busy2);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_ch !== 2'd0 || out_valid2 !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outs got ov=%b ob=%b och=%0d ov2=%b exp 0 0 0 0", out_valid, out_bit, out_ch, out_valid2);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      clear_reqs();
      step();
      tests_run++;
      if (o_busy !== 1'b0 || o_ov !== 1'b0 || o_ready !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_idle got busy=%b ov=%b ready=%b exp 0 0 0000", o_busy, o_ov, o_ready);
      end
   endtask

   // ch0 sends 1,0,1,1: y = 1,0,0,0, ctx[0] ends (0,1)
   task automatic test_single_channel();
      logic [15:0] rdy_e, busy_e, ov_e, ob_e;
      rdy_e = 16'h007C; busy_e = 16'h00FE; ov_e = 16'h0078; ob_e = 16'h0008;
      do_reset();
      pat[0] = 32'b1101; left[0] = 4;
      drive_reqs();
      for (int c = 0; c < 10; c++) begin
         step();
         tests_run++;
         if (o_ready !== (rdy_e[c] ? 4'b0001 : 4'b0000) || o_busy !== busy_e[c] || o_ov !== ov_e[c]) begin
            tests_failed++;
            $display("FAIL single c=%0d got ready=%b busy=%b ov=%b exp rdy=%b busy=%b ov=%b", c, o_ready, o_busy, o_ov, rdy_e[c], busy_e[c], ov_e[c]);
         end
         if (ov_e[c]) begin
            tests_run++;
            if (o_ob !== ob_e[c] || o_och !== 2'd0) begin
               tests_failed++;
               $display("FAIL single_bit c=%0d got y=%b ch=%0d exp y=%b ch=0", c, o_ob, o_och, ob_e[c]);
            end
         end
      end
      // from (0,1), x=0 gives y=1 (from a lost (0,0) it would be 0)
      pat[0] = 32'b0; left[0] = 1;
      drive_reqs();
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 3) begin
            tests_run++;
            if (o_ov !== 1'b1 || o_ob !== 1'b1 || o_och !== 2'd0) begin
               tests_failed++;
               $display("FAIL single_ctx got ov=%b y=%b ch=%0d exp 1 1 0", o_ov, o_ob, o_och);
            end
         end
      end
      wait_idle("single");
   endtask

   // BURST=2: ch0 1,0 | ch1 1,1 | ch0 1 -> y 1,0 | 1,1 | 0
   task automatic test_context();
      logic [15:0] ov_e, ob_e, ch1_e, r0_e, r1_e;
      ov_e = 16'h2318; ob_e = 16'h0308; ch1_e = 16'h0300; r0_e = 16'h300C; r1_e = 16'h0180;
      do_reset();
      pat2[0] = 32'b101; left2[0] = 3; pat2[1] = 32'b11; left2[1] = 2;
      drive_reqs();
      for (int c = 0; c < 16; c++) begin
         step();
         tests_run++;
         if (o_ready2 !== {2'b00, r1_e[c], r0_e[c]} || o_ov2 !== ov_e[c]) begin
            tests_failed++;
            $display("FAIL ctx c=%0d got ready=%b ov=%b exp ready=%b ov=%b", c, o_ready2, o_ov2, {2'b00, r1_e[c], r0_e[c]}, ov_e[c]);
         end
         if (ov_e[c]) begin
            tests_run++;
            if (o_ob2 !== ob_e[c] || o_och2 !== {1'b0, ch1_e[c]}) begin
               tests_failed++;
               $display("FAIL ctx_bit c=%0d got y=%b ch=%0d exp y=%b ch=%0d", c, o_ob2, o_och2, ob_e[c], ch1_e[c]);
            end
         end
      end
      // ctx[0] must now be (1,0): x=0 -> y=1
      pat2[0] = 32'b0; left2[0] = 1;
      drive_reqs();
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 3) begin
            tests_run++;
            if (o_ov2 !== 1'b1 || o_ob2 !== 1'b1 || o_och2 !== 2'd0) begin
               tests_failed++;
               $display("FAIL ctx_saved got ov=%b y=%b ch=%0d exp 1 1 0", o_ov2, o_ob2, o_och2);
            end
         end
      end
      wait_idle("ctx");
   endtask

   // all channels busy: bursts of 8 in order 0,1,2,3,0, 11-cycle period
   task automatic test_round_robin();
      logic [1:0] mdl [NCH];
      logic [2:0] res;
      logic [3:0] one, exp_rdy;
      logic       y_pend;
      int         acc_cnt [NCH];
      int         k, r;
      do_reset();
      pat[0] = 32'hA5C3_1F0E; pat[1] = 32'h3C96_E107; pat[2] = 32'hF00D_5A21; pat[3] = 32'h1234_ABCD;
      for (int ch = 0; ch < NCH; ch++) begin
         left[ch] = 100; mdl[ch] = 2'b00; acc_cnt[ch] = 0;
      end
      y_pend = 1'b0;
      drive_reqs();
      for (int c = 0; c < 57; c++) begin
         step();
         k = c / 11; r = c % 11;
         one = 4'b0001;
         exp_rdy = (r >= 2 && r <= 9) ? (one << (k % 4)) : 4'b0000;
         tests_run++;
         if (o_ready !== exp_rdy || o_busy !== (r != 0)) begin
            tests_failed++;
            $display("FAIL rr c=%0d got ready=%b busy=%b exp ready=%b busy=%b", c, o_ready, o_busy, exp_rdy, (r != 0));
         end
         if (r >= 3 && r <= 10) begin
            tests_run++;
            if (o_ov !== 1'b1 || o_och !== 2'(k % 4) || o_ob !== y_pend) begin
               tests_failed++;
               $display("FAIL rr_out c=%0d got ov=%b ch=%0d y=%b exp 1 %0d %b", c, o_ov, o_och, o_ob, k % 4, y_pend);
            end
         end
         if (exp_rdy != 4'b0000) begin
            res = ab_step(mdl[k % 4], o_bits[k % 4]);
            y_pend = res[2];
            mdl[k % 4] = res[1:0];
         end
         for (int ch = 0; ch < NCH; ch++) acc_cnt[ch] += int'(o_acc[ch]);
      end
      tests_run++;
      if (acc_cnt[0] != 16 || acc_cnt[1] != 8 || acc_cnt[2] != 8 || acc_cnt[3] != 8) begin
         tests_failed++;
         $display("FAIL rr_counts got %0d/%0d/%0d/%0d exp 16/8/8/8", acc_cnt[0], acc_cnt[1], acc_cnt[2], acc_cnt[3]);
      end
      wait_idle("rr");
   endtask

   // ch2 sends 3 bits then drops; ch3 is granted next
   task automatic test_early_release();
      logic [15:0] r2_e, r3_e, busy_e, ov_e;
      int          pulses2;
      r2_e = 16'h003C; r3_e = 16'h0600; busy_e = 16'h077E; ov_e = 16'h0438;
      pulses2 = 0;
      do_reset();
      pat[2] = 32'b011; left[2] = 3; pat[3] = 32'b0; left[3] = 100;
      drive_reqs();
      for (int c = 0; c < 11; c++) begin
         step();
         tests_run++;
         if (o_ready !== {r3_e[c], r2_e[c], 2'b00} || o_busy !== busy_e[c] || o_ov !== ov_e[c]) begin
            tests_failed++;
            $display("FAIL early c=%0d got ready=%b busy=%b ov=%b exp ready=%b busy=%b ov=%b", c, o_ready, o_busy, o_ov, {r3_e[c], r2_e[c], 2'b00}, busy_e[c], ov_e[c]);
         end
         if (o_ov && o_och == 2'd2) pulses2++;
      end
      tests_run++;
      if (pulses2 != 3) begin
         tests_failed++;
         $display("FAIL early_pulses got %0d exp 3", pulses2);
      end
      wait_idle("early");
   endtask

   // clear with accepted bit: x0=0 y=0, x1=1 y=0 (old state), x2=1 y=1 (from (0,0))
   task automatic test_clear_run();
      logic [15:0] ov_e, ob_e;
      ov_e = 16'h0038; ob_e = 16'h0020;
      do_reset();
      pat[0] = 32'b110; left[0] = 3;
      drive_reqs();
      for (int c = 0; c < 8; c++) begin
         step();
         tests_run++;
         if (o_ov !== ov_e[c] || (ov_e[c] && o_ob !== ob_e[c])) begin
            tests_failed++;
            $display("FAIL clear c=%0d got ov=%b y=%b exp ov=%b y=%b", c, o_ov, o_ob, ov_e[c], ob_e[c]);
         end
         ch_clear = (c == 2) ? 4'b0001 : 4'b0000;
      end
      // ctx[0] must be (0,0): x=0 -> y=0
      pat[0] = 32'b0; left[0] = 1;
      drive_reqs();
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 3) begin
            tests_run++;
            if (o_ov !== 1'b1 || o_ob !== 1'b0) begin
               tests_failed++;
               $display("FAIL clear_ctx got ov=%b y=%b exp 1 0", o_ov, o_ob);
            end
         end
      end
      wait_idle("clear");
   endtask

   task automatic test_reset_mid();
      do_reset();
      // give ch1 a non-zero context (0,1)
      pat[1] = 32'b0; left[1] = 1;
      drive_reqs();
      for (int c = 0; c < 6; c++) step();
      pat[0] = 32'b0; left[0] = 100; pat[1] = 32'b0; left[1] = 100;
      drive_reqs();
      for (int c = 0; c < 4; c++) step();
      reset = 1'b1;
      left[0] = 1; left[1] = 1;
      drive_reqs();
      step();
      tests_run++;
      if (o_ready !== 4'b0000 || o_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_comb got ready=%b busy=%b exp 0000 0", o_ready, o_busy);
      end
      reset = 1'b0;
      step();
      tests_run++;
      if (o_ready !== 4'b0000 || o_busy !== 1'b0 || o_ov !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_idle got ready=%b busy=%b ov=%b exp 0000 0 0", o_ready, o_busy, o_ov);
      end
      for (int c = 6; c < 14; c++) begin
         step();
         if (c == 7 || c == 12) begin
            tests_run++;
            if (o_ready !== ((c == 7) ? 4'b0001 : 4'b0010)) begin
               tests_failed++;
               $display("FAIL mid_grant c=%0d got ready=%b exp %b", c, o_ready, (c == 7) ? 4'b0001 : 4'b0010);
            end
         end
         if (c == 8 || c == 13) begin
            tests_run++;
            if (o_ov !== 1'b1 || o_ob !== 1'b0 || o_och !== ((c == 8) ? 2'd0 : 2'd1)) begin
               tests_failed++;
               $display("FAIL mid_out c=%0d got ov=%b y=%b ch=%0d exp 1 0 %0d", c, o_ov, o_ob, o_och, (c == 8) ? 0 : 1);
            end
         end
      end
      wait_idle("mid");
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_context();
      test_round_robin();
      test_early_release();
      test_clear_run();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running exp finished");
      $fatal(1, "watchdog");
   end

endmodule
